prbs_sym_checker: RTL and testbench

//  Receive-side counterpart of lfsr_gen_max: self-synchronising PRBS checker on sliced 16-QAM symbols.

---
 rtl/prbs_sym_checker_if.sv | 28 ++
 rtl/prbs_sym_checker.sv | 174 +++++++++++++++++
 tb/tb_prbs_sym_checker.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_sym_checker_if.sv
`default_nettype none
// ============================================================================
// prbs_sym_checker_if : symbol-in / status-out bundle of prbs_sym_checker
// Revision: 1.0 - initial release
// ============================================================================
interface prbs_sym_checker_if #(
    parameter int CNT_W = 24
);
    logic             sym_clk_en;
    logic [3:0]       rx_data;
    logic             locked;
    logic             sym_err;
    logic [2:0]       bit_err_sym;
    logic [CNT_W-1:0] err_total;
    logic             meas_done;
    logic             lock_loss;

    modport master (
        output sym_clk_en, rx_data,
        input  locked, sym_err, bit_err_sym, err_total, meas_done, lock_loss
    );

    modport slave (
        input  sym_clk_en, rx_data,
        output locked, sym_err, bit_err_sym, err_total, meas_done, lock_loss
    );
endinterface
`default_nettype wire

// File: rtl/prbs_sym_checker.sv
`default_nettype none
// ============================================================================
// prbs_sym_checker : self-synchronising x^22+x^21+1 PRBS checker on 16-QAM symbols
// Optional: ZERO_LOCK_GUARD_EN blocks locking onto an all-zero history.
// Revision: 1.0 - initial release
// ============================================================================
module prbs_sym_checker #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_WIN = 64,
    parameter int UNLOCK_THR = 8,
    parameter int MEAS_LEN   = 4096,
    parameter int CNT_W      = 24
) (
    input  wire logic          sys_clk,
    input  wire logic          reset,
    prbs_sym_checker_if.slave  bus
);
    localparam int MCW = $clog2(LOCK_CNT + 1);
    localparam int WCW = $clog2(UNLOCK_WIN + 1);
    localparam int ECW = $clog2(UNLOCK_THR + 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [21:0]      hist;
    logic [2:0]       fill_cnt;
    logic [MCW-1:0]   match_cnt;
    logic [WCW-1:0]   win_cnt;
    logic [ECW-1:0]   win_err;
    logic [CNT_W-1:0] sym_cnt;
    logic [CNT_W-1:0] bit_acc;

    logic             locked_q;
    logic             sym_err_q;
    logic [2:0]       bit_err_q;
    logic [CNT_W-1:0] err_total_q;
    logic             meas_done_q;
    logic             lock_loss_q;

    logic [3:0]       pred;
    logic [3:0]       mism;
    logic [2:0]       pop;
    logic [21:0]      hist_next;
    logic [CNT_W:0]   acc_ext;
    logic [CNT_W-1:0] acc_sat;
    logic [ECW-1:0]   win_err_next;
    logic             unlock;
    logic             win_end;
    logic             meas_end;
    logic             zero_block;

    assign pred = {hist[21] ^ hist[20], hist[20] ^ hist[19],
                   hist[19] ^ hist[18], hist[18] ^ hist[17]};
    assign mism = bus.rx_data ^ pred;
    assign pop  = 3'(mism[0]) + 3'(mism[1]) + 3'(mism[2]) + 3'(mism[3]);

    // Once locked the predictor feeds itself, so line errors never enter the history.
    assign hist_next = {hist[17:0], (state == ST_LOCKED) ? pred : bus.rx_data};

    assign acc_ext      = {1'b0, bit_acc} + {{(CNT_W-2){1'b0}}, pop};
    assign acc_sat      = acc_ext[CNT_W] ? {CNT_W{1'b1}} : acc_ext[CNT_W-1:0];
    assign win_err_next = win_err + ECW'(mism != 4'd0);
    assign unlock       = (win_err_next >= ECW'(UNLOCK_THR));
    assign win_end      = (win_cnt == WCW'(UNLOCK_WIN - 1));
    assign meas_end     = (sym_cnt == CNT_W'(MEAS_LEN - 1));

`ifdef ZERO_LOCK_GUARD_EN
    assign zero_block = (hist_next == 22'd0);
`else
    assign zero_block = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_FILL;
            hist        <= 22'd0;
            fill_cnt    <= 3'd0;
            match_cnt   <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            sym_cnt     <= '0;
            bit_acc     <= '0;
            locked_q    <= 1'b0;
            sym_err_q   <= 1'b0;
            bit_err_q   <= 3'd0;
            err_total_q <= '0;
            meas_done_q <= 1'b0;
            lock_loss_q <= 1'b0;
        end else begin
            sym_err_q   <= 1'b0;
            meas_done_q <= 1'b0;
            lock_loss_q <= 1'b0;
            if (bus.sym_clk_en) begin
                hist <= hist_next;
                case (state)
                    ST_FILL: begin
                        if (fill_cnt >= 3'd5) begin
                            if (!zero_block) begin
                                state     <= ST_VERIFY;
                                fill_cnt  <= 3'd0;
                                match_cnt <= '0;
                            end else begin
                                fill_cnt  <= 3'd6;
                            end
                        end else begin
                            fill_cnt <= fill_cnt + 3'd1;
                        end
                    end
                    ST_VERIFY: begin
                        if (mism != 4'd0) begin
                            match_cnt <= '0;
                        end else if (match_cnt >= MCW'(LOCK_CNT - 1)) begin
                            if (!zero_block) begin
                                state     <= ST_LOCKED;
                                locked_q  <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= MCW'(LOCK_CNT);
                            end
                        end else begin
                            match_cnt <= match_cnt + MCW'(1);
                        end
                    end
                    ST_LOCKED: begin
                        sym_err_q <= (mism != 4'd0);
                        bit_err_q <= pop;
                        if (unlock) begin
                            // err_total intentionally keeps the last completed window
                            state       <= ST_FILL;
                            locked_q    <= 1'b0;
                            lock_loss_q <= 1'b1;
                            fill_cnt    <= 3'd0;
                            win_cnt     <= '0;
                            win_err     <= '0;
                            sym_cnt     <= '0;
                            bit_acc     <= '0;
                        end else begin
                            if (win_end) begin
                                win_cnt <= '0;
                                win_err <= '0;
                            end else begin
                                win_cnt <= win_cnt + WCW'(1);
                                win_err <= win_err_next;
                            end
                            if (meas_end) begin
                                err_total_q <= acc_sat;
                                meas_done_q <= 1'b1;
                                sym_cnt     <= '0;
                                bit_acc     <= '0;
                            end else begin
                                sym_cnt <= sym_cnt + CNT_W'(1);
                                bit_acc <= acc_sat;
                            end
                        end
                    end
                    default: state <= ST_FILL;
                endcase
            end
        end
    end

    assign bus.locked      = locked_q;
    assign bus.sym_err     = sym_err_q;
    assign bus.bit_err_sym = bit_err_q;
    assign bus.err_total   = err_total_q;
    assign bus.meas_done   = meas_done_q;
    assign bus.lock_loss   = lock_loss_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_sym_checker.sv
`default_nettype none
// ============================================================================
// tb_prbs_sym_checker : directed + randomized bench against a stream-level model
// Revision: 1.0 - initial release
// ============================================================================
module tb_prbs_sym_checker;
    localparam int LOCK_CNT   = 16;
    localparam int UNLOCK_WIN = 64;
    localparam int UNLOCK_THR = 8;
    localparam int MEAS_LEN   = 4096;
    localparam int CNT_W      = 24;
    localparam int SAT        = (1 << CNT_W) - 1;
    localparam int P_FILL     = 0;
    localparam int P_VERIFY   = 1;
    localparam int P_LOCKED   = 2;

    logic sys_clk = 1'b0;
    logic reset   = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    prbs_sym_checker_if #(.CNT_W(CNT_W)) bus ();

    prbs_sym_checker #(
        .LOCK_CNT(LOCK_CNT), .UNLOCK_WIN(UNLOCK_WIN), .UNLOCK_THR(UNLOCK_THR),
        .MEAS_LEN(MEAS_LEN), .CNT_W(CNT_W)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus.master)
    );

    always #5 sys_clk = ~sys_clk;

    // Ideal transmit stream: last 22 emitted bits, oldest first.
    bit q[$];

    int m_phase, m_fill, m_match, m_win, m_werr, m_sym, m_acc;
    int m_locked, m_serr, m_bes, m_total, m_md, m_ll;

    function automatic logic [3:0] gen_sym();
        logic [3:0] s;
        for (int k = 3; k >= 0; k--) begin
            bit b;
            b = q[0] ^ q[1];
            q.push_back(b);
            void'(q.pop_front());
            s[k] = b;
        end
        return s;
    endfunction

    function automatic bit blocked();
`ifdef ZERO_LOCK_GUARD_EN
        foreach (q[k]) if (q[k]) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_phase = P_FILL; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
        m_sym = 0; m_acc = 0; m_locked = 0; m_serr = 0; m_bes = 0;
        m_total = 0; m_md = 0; m_ll = 0;
    endtask

    task automatic model_step(input logic [3:0] err);
        int e;
        m_serr = 0; m_md = 0; m_ll = 0;
        if (m_phase == P_FILL) begin
            m_fill++;
            if (m_fill >= 6) begin
                m_fill = 6;
                if (!blocked()) begin m_phase = P_VERIFY; m_fill = 0; m_match = 0; end
            end
        end else if (m_phase == P_VERIFY) begin
            m_match++;
            if (m_match >= LOCK_CNT) begin
                m_match = LOCK_CNT;
                if (!blocked()) begin m_phase = P_LOCKED; m_locked = 1; m_match = 0; end
            end
        end else begin
            e      = $countones(err);
            m_bes  = e;
            m_serr = (e != 0);
            m_win++;
            m_werr += (e != 0) ? 1 : 0;
            m_sym++;
            m_acc  = (m_acc + e > SAT) ? SAT : m_acc + e;
            if (m_werr >= UNLOCK_THR) begin
                m_phase = P_FILL; m_locked = 0; m_ll = 1; m_fill = 0;
                m_win = 0; m_werr = 0; m_sym = 0; m_acc = 0;
            end else begin
                if (m_win == UNLOCK_WIN) begin m_win = 0; m_werr = 0; end
                if (m_sym == MEAS_LEN) begin
                    m_total = m_acc; m_md = 1; m_acc = 0; m_sym = 0;
                end
            end
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {1'b0, bus.locked, bus.sym_err, bus.bit_err_sym, bus.meas_done,
                bus.lock_loss, bus.err_total};
    endfunction

    function automatic logic [31:0] model_vec();
        return {1'b0, m_locked[0], m_serr[0], m_bes[2:0], m_md[0], m_ll[0],
                m_total[CNT_W-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic [3:0] err);
        logic [3:0] e;
        @(negedge sys_clk);
        e = (m_phase == P_LOCKED) ? err : 4'h0;
        if (en) bus.rx_data = gen_sym() ^ e;
        else    bus.rx_data = 4'($urandom);
        bus.sym_clk_en = en;
        @(posedge sys_clk);
        #1;
        if (en) model_step(e);
        else begin m_serr = 0; m_md = 0; m_ll = 0; end
        chk("outs", dut_vec(), model_vec());
    endtask

    // One strobe, sometimes preceded by an idle cycle.
    task automatic sym(input logic [3:0] err);
        if ($urandom_range(0, 3) == 0) cyc(1'b0, 4'h0);
        cyc(1'b1, err);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sym_clk_en = 1'b0;
        bus.rx_data    = 4'h0;
        repeat (22) q.push_back(1'b1);
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_outs", dut_vec(), 32'h0);
        @(negedge sys_clk);
        reset = 1'b1;

        // Clean stream: lock on strobe 22, first window clean
        for (int i = 0; i < 22; i++) begin
            sym(4'h0);
            chk("lock_at_22", {31'd0, bus.locked}, {31'd0, (i == 21)});
        end
        for (int i = 0; i < MEAS_LEN; i++) sym(4'h0);
        chk("win1_done", {31'd0, bus.meas_done}, 32'd1);
        chk("win1_total", {8'd0, bus.err_total}, 32'd0);

        // Single-bit error, no propagation
        for (int i = 0; i < MEAS_LEN; i++) begin
            sym((i == 100) ? 4'b0100 : 4'h0);
            if (i == 100) begin
                chk("one_err_pulse", {31'd0, bus.sym_err}, 32'd1);
                chk("one_err_bits", {29'd0, bus.bit_err_sym}, 32'd1);
            end
            if (i == 101) chk("one_err_gone", {31'd0, bus.sym_err}, 32'd0);
        end
        chk("win2_total", {8'd0, bus.err_total}, 32'd1);

        // Error on the last symbol of a window is counted in that window
        for (int i = 0; i < MEAS_LEN; i++) sym((i == MEAS_LEN - 1) ? 4'hF : 4'h0);
        chk("win3_done", {31'd0, bus.meas_done}, 32'd1);
        chk("win3_total", {8'd0, bus.err_total}, 32'd4);

        // Eight bad symbols at the start of a loss-of-lock window
        for (int i = 0; i < 8; i++) begin
            sym(4'hF);
            chk("loss_pulse", {31'd0, bus.lock_loss}, {31'd0, (i == 7)});
        end
        chk("loss_unlocked", {31'd0, bus.locked}, 32'd0);
        chk("loss_keeps_total", {8'd0, bus.err_total}, 32'd4);
        for (int i = 0; i < 22; i++) begin
            sym(4'h0);
            chk("relock_22", {31'd0, bus.locked}, {31'd0, (i == 21)});
        end

        // Sparse random errors
        for (int i = 0; i < 600; i++)
            sym(($urandom_range(0, 31) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);

        // Asynchronous reset mid-window
        for (int k = 0; k < 8000 && !(m_phase == P_LOCKED && m_sym == 2000); k++) sym(4'h0);
        chk("pre_reset_locked", {31'd0, bus.locked}, 32'd1);
        #2;
        reset = 1'b0;
        bus.sym_clk_en = 1'b0;
        #1;
        chk("async_reset_outs", dut_vec(), 32'h0);
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b1;
        for (int i = 0; i < 22; i++) begin
            sym(4'h0);
            chk("post_reset_lock", {31'd0, bus.locked}, {31'd0, (i == 21)});
        end
        for (int i = 0; i < 50; i++) sym(4'h0);

        // All-zero input
        @(negedge sys_clk);
        reset = 1'b0;
        bus.sym_clk_en = 1'b0;
        model_reset();
        foreach (q[k]) q[k] = 1'b0;
        @(negedge sys_clk);
        reset = 1'b1;
        for (int i = 0; i < 30; i++) sym(4'h0);
`ifdef ZERO_LOCK_GUARD_EN
        chk("zero_input_lock", {31'd0, bus.locked}, 32'd0);
`else
        chk("zero_input_lock", {31'd0, bus.locked}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
